uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmit line among NREQ requesters (game logic, debug, score reporter, etc.) using round-robin arbitration.
- Serialises the granted byte as 8N1, LSB first, with tx idling high.
- Timing comes from the sample-tick pulse of the baud rate generator. That generator is configured for 16× oversampling: M=651 gives 9600 baud at 100 MHz.
- Sits between the requester modules and the Basys 3 USB-UART TX pin.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DBITS, 8, data bits per frame
- SB_TICK, 16, sample ticks in stop bit (16 = 1 stop bit)
- OS, 16, sample ticks per start/data bit

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle sample pulse at OS× baud
- req  in  NREQ  per-requester transmit request, level
- data_in  in  NREQ*DBITS  byte for requester i at bits [i*DBITS +: DBITS]
- ack  out  NREQ  one-cycle pulse: byte of requester i accepted and latched
- grant  out  NREQ  one-hot owner of the line; zero when idle
- busy  out  1  high while a frame is in progress
- tx_done  out  1  one-cycle pulse at end of stop bit
- tx  out  1  serial output

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, tx=1, grant=0, ack=0, busy=0, tx_done=0
  - rr_ptr=0, tick count s=0, bit count n=0, shift register=0
- Reset mid-frame aborts immediately: tx returns high and the frame is lost.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - tx=1; ticks are ignored.
  - If req≠0, select the first asserted index scanning rr_ptr, rr_ptr+1, … with wrap mod NREQ.
  - On the next edge: latch data_in slice into the shift register, pulse ack[i], set grant=1<<i, set rr_ptr=(i+1) mod NREQ, set busy=1, s=0, then go to START.
  - Selection is combinational on the current req. Arbitration latency is one clock from req to ack.
- START:
  - tx=0.
  - On tick: if s==OS-1, set s=0, n=0 and go to DATA; otherwise s+1.
- DATA:
  - tx=shift[0].
  - On tick with s==OS-1: s=0 and shift right. If n==DBITS-1 go to STOP, otherwise n+1.
  - On any other tick: s+1.
- STOP:
  - tx=1.
  - On tick with s==SB_TICK-1: go to IDLE, pulse tx_done, clear grant and busy.
- Frame length is OS*(1+DBITS)+SB_TICK ticks: 160 ticks with defaults.
- Back-to-back frames: the FSM spends at least one clock in IDLE after tx_done before the next ack.
  - tx stays high through that gap.
  - If req persists, the next frame starts in the cycle after IDLE is entered.
- Requester handshake:
  - Hold req and data_in stable until ack.
  - Deassert req in the cycle after ack, or keep it high to send another byte. A held request is re-arbitrated fairly behind the others.
  - data_in changes after ack do not affect the frame in flight.
- req dropped before ack: no transfer, no ack.
- req changes during a frame: ignored until IDLE.
- Simultaneous requests: exactly one ack per frame, chosen by rr_ptr. A requester waits at most NREQ-1 frames.
- tick coinciding with the IDLE→START transition is not counted. Counting starts at the next tick.
- All outputs are registered except grant/busy decoding, which may be combinational from registered state. tx must be glitch-free (registered).

Test Plan:
- Reset then idle, with 200 ticks and req=0:
  - tx=1, grant=0, busy=0, and no ack/tx_done throughout.
- Single request, req=4'b0001, data_in[7:0]=8'hA5:
  - ack[0] one clock later, grant=0001.
  - tx reads 0, 1,0,1,0,0,1,0,1, 1, each start/data bit lasting 16 ticks.
  - tx_done after 160 ticks; grant=0.
- Contention, req=4'b1111 held continuously:
  - Grants occur in order 0,1,2,3,0.
  - Exactly one ack per frame, with at least one IDLE clock between frames.
- Fairness after wrap, with rr_ptr=3 and req=4'b1001:
  - Grant goes to 3, then 0.
  - With req=4'b0110 arriving while rr_ptr=1, grant goes to 1, then 2.
- Data stability: after ack for byte 8'h3C, change data_in to 8'hFF.
  - The serialised byte is still 8'h3C.
- Reset mid-DATA, asserting reset at tick 70 of a frame:
  - tx=1 and grant=0 immediately; no tx_done.
  - After release, a pending req=0010 is served with a full correct frame and rr_ptr restarts at 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmit line among NREQ requesters.
// Bit timing is derived from the oversampling tick of an external baud generator.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBITS-1:0]   data_in,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    tx_done,
  output logic                    tx
);

  // state | meaning
  // IDLE  | line high, arbitrating among asserted requests
  // START | start bit (tx low) for OS ticks
  // DATA  | DBITS data bits, LSB first, OS ticks each
  // STOP  | stop bit (tx high) for SB_TICK ticks
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int PW   = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBITS-1:0]  shift_q, shift_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              done_q, done_d;
  logic              tx_q, tx_d;

  logic [PW-1:0]     sel;
  logic              found;
  int                idx;

  // First asserted request at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    ack_d   = '0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          shift_d = data_in[int'(sel)*DBITS +: DBITS];
          ack_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          if (sel == PW'(NREQ-1)) rr_d = '0;
          else                    rr_d = sel + 1'b1;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == SW'(OS-1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == SW'(OS-1)) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == NW'(DBITS-1)) state_d = STOP;
            else                     n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK-1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the next state so the pin changes exactly with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign ack     = ack_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = done_q;
  assign tx      = tx_q;

endmodule
